link_arbiter: RTL
=================

LINK_ARBITER -- requirements
Module: link_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8: data byte width.
REQ-002 SHALL have parameter MAX_BURST, default 4: maximum consecutive locked transfers per grant, range 1..15.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_i, input, 4: per-requester 4-phase request.
REQ-006 SHALL have port data_i, input, 4*DW: per-requester data; requester n occupies bits [n*DW +: DW].
REQ-007 SHALL have port lock_i, input, 4: per-requester burst lock, which asks to keep the grant after the current transfer.
REQ-008 SHALL have port ack_o, input-side ack return, output, 4: per-requester ack.
REQ-009 SHALL have port req_o, output, 1: request to the shared link slave.
REQ-010 SHALL have port data_o, output, DW: data to the shared link slave.
REQ-011 SHALL have port ack, input, 1: ack from the shared link slave.
REQ-012 SHALL have port gnt, output, 4: one-hot registered grant, or all zero when the link is free.
REQ-013 SHALL have port busy, output, 1: high whenever gnt is nonzero.

Function
REQ-014 SHALL implement states IDLE, ACTIVE, RELEASE and HOLD, plus a 2-bit round-robin pointer ptr and a burst counter bcnt.
REQ-015 In IDLE with req_i nonzero: SHALL select the first set req_i[n] searching n = ptr, ptr+1, ... mod 4; SHALL register gnt = onehot(n) and bcnt = 1; SHALL go to ACTIVE on the next edge (1-cycle grant latency).
REQ-016 In IDLE with req_i = 0: SHALL stay in IDLE with gnt = 0.
REQ-017 req_o, data_o and ack_o SHALL be combinational from the registered gnt:
- req_o = |(gnt & req_i).
- data_o = data_i of the granted requester, or 0 when gnt = 0.
- ack_o = gnt & {4{ack}}.
REQ-018 ACTIVE: when ack = 1, SHALL go to RELEASE.
REQ-019 ACTIVE: if the granted req_i drops while ack = 0 (abort), SHALL clear gnt, set ptr = n+1, and go to IDLE.
REQ-020 RELEASE: SHALL wait until ack = 0 and the granted req_i = 0 in the same cycle; that is transfer completion.
REQ-021 On completion with lock_i[n] = 1 and bcnt < MAX_BURST: SHALL keep gnt and go to HOLD.
REQ-022 On completion in all other cases: SHALL clear gnt, set ptr = n+1 mod 4, and go to IDLE.
REQ-023 HOLD: if the granted req_i = 1, SHALL increment bcnt and go to ACTIVE.
REQ-024 HOLD: if req_i[n] = 0 and lock_i[n] = 0, SHALL release as in REQ-022.
REQ-025 HOLD: otherwise SHALL stay in HOLD.
REQ-026 Requests from non-granted requesters SHALL NOT affect req_o, data_o or ack_o in any state.
REQ-027 On simultaneous requests, the pointer order of REQ-015 SHALL decide the winner.
REQ-028 gnt SHALL never change in ACTIVE or RELEASE except on abort (REQ-019).
REQ-029 Lock on burst expiry: when bcnt = MAX_BURST, the SHALL release the grant even with lock_i[n] = 1 (forced rotation).
REQ-030 ptr SHALL wrap from 3 to 0.
REQ-031 bcnt SHALL be 4 bits wide and SHALL never exceed MAX_BURST.

Reset
REQ-032 On rst = 1 at a clock edge, the block SHALL set state = IDLE, gnt = 0, ptr = 0 and bcnt = 0.
REQ-033 Under reset, outputs SHALL be req_o = 0, data_o = 0, ack_o = 0 and busy = 0.
REQ-034 rst SHALL take priority over all transitions, including in mid-transfer ACTIVE or RELEASE; the slave sees req_o fall on the edge after reset.

Verification
REQ-035 The bench SHALL cover a single transfer: req_i = 0001, data0 = A0 -> gnt = 0001 one cycle later, req_o = 1, data_o = A0; after ack 1 then 0 and req_i[0] dropped -> gnt = 0 and ptr = 1.
REQ-036 The bench SHALL cover round-robin: req_i = 1111 held, with each transfer completed -> gnt sequence 0001, 0010, 0100, 1000, 0001.
REQ-037 The bench SHALL cover a locked burst: requester 2 with lock = 1, sending A0..A3 then a fifth byte A4, MAX_BURST = 4, while requester 3 is pending -> A0..A3 go out under gnt = 0100, then gnt = 1000 before A4.
REQ-038 The bench SHALL cover isolation: requester 1 granted while requester 3 toggles req and data (data3 = 55) -> req_o and data_o track requester 1 only, and ack_o[3] = 0 throughout.
REQ-039 The bench SHALL cover abort: granted requester 0 drops req before ack -> gnt = 0 next edge, then pending requester 1 is granted.
REQ-040 The bench SHALL cover reset mid-transfer: rst = 1 in RELEASE -> gnt = 0, req_o = 0 and ack_o = 0 after the edge; the next grant after release goes to requester 0.

Source files
------------

// File: rtl/link_arbiter.sv
// link_arbiter: four-requester round-robin arbiter for a shared 4-phase link.
// Grants are registered one-hot and may be held across a locked burst of up
// to MAX_BURST transfers before the grant is forced to rotate.
module link_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req_i,
  input  logic [4*DW-1:0] data_i,
  input  logic [3:0]      lock_i,
  output logic [3:0]      ack_o,
  output logic            req_o,
  output logic [DW-1:0]   data_o,
  input  logic            ack,
  output logic [3:0]      gnt,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  state_t     state;
  state_t     state_next;
  logic [3:0] gnt_next;
  logic [1:0] ptr;
  logic [1:0] ptr_next;
  logic [3:0] bcnt;
  logic [3:0] bcnt_next;

  logic [1:0] gnt_idx;
  logic       gnt_req;
  logic       gnt_lock;
  logic       found;
  logic [1:0] win_idx;
  logic [1:0] search_idx;

  // Index of the currently granted requester (gnt is one-hot or zero)
  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < 4; k++) begin
      if (gnt[k]) begin
        gnt_idx = 2'(k);
      end
    end
  end

  assign gnt_req  = |(gnt & req_i);
  assign gnt_lock = |(gnt & lock_i);

  // Round-robin search starting at ptr and wrapping modulo 4
  always_comb begin
    found      = 1'b0;
    win_idx    = ptr;
    search_idx = ptr;
    for (int k = 0; k < 4; k++) begin
      search_idx = ptr + 2'(k);
      if (!found && req_i[search_idx]) begin
        found   = 1'b1;
        win_idx = search_idx;
      end
    end
  end

  // Next-state logic for the grant FSM, pointer and burst counter
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    ptr_next   = ptr;
    bcnt_next  = bcnt;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_next   = 4'b0001 << win_idx;
          bcnt_next  = 4'd1;
          state_next = ACTIVE;
        end else begin
          gnt_next = 4'b0000;
        end
      end
      ACTIVE: begin
        if (ack) begin
          state_next = RELEASE;
        end else if (!gnt_req) begin
          // Requester gave up before the slave answered
          gnt_next   = 4'b0000;
          ptr_next   = gnt_idx + 2'd1;
          state_next = IDLE;
        end
      end
      RELEASE: begin
        if (!ack && !gnt_req) begin
          if (gnt_lock && (bcnt < BURST_LIMIT)) begin
            state_next = HOLD;
          end else begin
            gnt_next   = 4'b0000;
            ptr_next   = gnt_idx + 2'd1;
            state_next = IDLE;
          end
        end
      end
      HOLD: begin
        if (gnt_req) begin
          bcnt_next  = bcnt + 4'd1;
          state_next = ACTIVE;
        end else if (!gnt_lock) begin
          gnt_next   = 4'b0000;
          ptr_next   = gnt_idx + 2'd1;
          state_next = IDLE;
        end
      end
      default: begin
        gnt_next   = 4'b0000;
        state_next = IDLE;
      end
    endcase
  end

  // State, grant, pointer and burst counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      ptr   <= 2'd0;
      bcnt  <= 4'd0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      ptr   <= ptr_next;
      bcnt  <= bcnt_next;
    end
  end

  // Data path to the slave: only the granted requester's byte passes
  always_comb begin
    data_o = '0;
    for (int k = 0; k < 4; k++) begin
      if (gnt[k]) begin
        data_o = data_i[k*DW +: DW];
      end
    end
  end

  assign req_o = |(gnt & req_i);
  assign ack_o = gnt & {4{ack}};
  assign busy  = |gnt;

endmodule
